stack_controller: RTL and testbench

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_stack_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// Button-driven 8-bit calculator stack that keeps its elements in an external
// 128 x 8 memory and shows the top-of-stack byte on two seven-segment digits.
module stack_controller #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btns,
  input  logic [7:0] swtchs,
  output logic       cs,
  output logic       we,
  output logic [6:0] addr,
  output logic [7:0] data_out_ctrl,
  input  logic [7:0] data_bus,
  output logic [7:0] leds,
  output logic       err,
  output logic [6:0] segs,
  output logic [3:0] an
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    RD_A,
    RD_B,
    ALU_WR,
    FETCH
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_prev;
  logic [3:0] w_rise;
  logic [3:0] w_req;
  logic       w_reqPush;
  logic       w_reqPop;
  logic       w_reqAlu;
  logic       w_reqSub;

  logic [7:0] r_count;
  logic [7:0] r_top;
  logic       r_err;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_wdata;
  logic       r_isSub;
  logic [REFRESH_BITS-1:0] r_refresh;

  logic [6:0] w_topAddr;
  logic [6:0] w_belowAddr;
  logic [6:0] w_pushAddr;
  logic [7:0] w_aluResult;
  logic [3:0] w_nibble;
  logic       w_digitSel;

  // Element i lives at address 127-i, so the top sits at 128-count; the
  // 7-bit wrap of the subtraction gives exactly that address.
  assign w_topAddr   = 7'd0 - r_count[6:0];
  assign w_belowAddr = 7'd1 - r_count[6:0];
  assign w_pushAddr  = 7'd127 - r_count[6:0];
  assign w_aluResult = r_isSub ? (r_b - r_a) : (r_b + r_a);

  // Only a fresh press seen while idle becomes a request; the lowest button
  // index wins when several arrive together.
  assign w_rise    = r_sync2 & ~r_prev;
  assign w_req     = (r_state == IDLE) ? w_rise : 4'b0000;
  assign w_reqPush = w_req[0];
  assign w_reqPop  = w_req[1] & ~w_req[0];
  assign w_reqAlu  = (w_req[2] | w_req[3]) & ~w_req[1] & ~w_req[0];
  assign w_reqSub  = ~w_req[2];

  assign leds = r_count;
  assign err  = r_err;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_prev  <= 4'b0000;
    end else begin
      r_sync1 <= btns;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state selection; illegal requests leave the machine in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_reqPush) begin
          if (!r_count[7]) w_nextState = PUSH_WR;
        end else if (w_reqPop) begin
          if (r_count != 8'd0) w_nextState = FETCH;
        end else if (w_reqAlu) begin
          if (r_count >= 8'd2) w_nextState = RD_A;
        end
      end
      PUSH_WR: w_nextState = FETCH;
      RD_A:    w_nextState = RD_B;
      RD_B:    w_nextState = ALU_WR;
      ALU_WR:  w_nextState = FETCH;
      FETCH:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: count, error flag, operand latches and the cached top value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
      r_top   <= 8'd0;
      r_err   <= 1'b0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_wdata <= 8'd0;
      r_isSub <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_reqPush) begin
            if (!r_count[7]) begin
              r_wdata <= swtchs;
              r_err   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_reqPop) begin
            if (r_count != 8'd0) begin
              r_count <= r_count - 8'd1;
              r_err   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_reqAlu) begin
            if (r_count >= 8'd2) begin
              r_isSub <= w_reqSub;
              r_err   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PUSH_WR: r_count <= r_count + 8'd1;
        RD_A:    r_a <= data_bus;
        RD_B:    r_b <= data_bus;
        ALU_WR:  r_count <= r_count - 8'd1;
        FETCH:   r_top <= (r_count != 8'd0) ? data_bus : 8'd0;
        default: r_top <= r_top;
      endcase
    end
  end

  // Memory strobes; held off while reset is high so an aborted op never writes.
  always_comb begin
    cs            = 1'b0;
    we            = 1'b0;
    addr          = 7'd0;
    data_out_ctrl = 8'd0;
    case (r_state)
      PUSH_WR: begin
        cs            = 1'b1;
        we            = 1'b1;
        addr          = w_pushAddr;
        data_out_ctrl = r_wdata;
      end
      RD_A: begin
        cs   = 1'b1;
        addr = w_topAddr;
      end
      RD_B: begin
        cs   = 1'b1;
        addr = w_belowAddr;
      end
      ALU_WR: begin
        cs            = 1'b1;
        we            = 1'b1;
        addr          = w_belowAddr;
        data_out_ctrl = w_aluResult;
      end
      FETCH: begin
        cs   = (r_count != 8'd0);
        addr = w_topAddr;
      end
      default: cs = 1'b0;
    endcase
    if (rst) begin
      cs = 1'b0;
      we = 1'b0;
    end
  end

  // Free-running refresh counter; its MSB alternates the two digits.
  always_ff @(posedge clk) begin
    if (rst) r_refresh <= '0;
    else     r_refresh <= r_refresh + REFRESH_BITS'(1);
  end

  assign w_digitSel = r_refresh[REFRESH_BITS-1];
  assign w_nibble   = w_digitSel ? r_top[7:4] : r_top[3:0];
  assign an         = w_digitSel ? 4'b1101 : 4'b1110;

  // Active-low hex decoder, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    segs = 7'b1111111;
    case (w_nibble)
      4'h0: segs = 7'b1000000;
      4'h1: segs = 7'b1111001;
      4'h2: segs = 7'b0100100;
      4'h3: segs = 7'b0110000;
      4'h4: segs = 7'b0011001;
      4'h5: segs = 7'b0010010;
      4'h6: segs = 7'b0000010;
      4'h7: segs = 7'b1111000;
      4'h8: segs = 7'b0000000;
      4'h9: segs = 7'b0010000;
      4'hA: segs = 7'b0001000;
      4'hB: segs = 7'b0000011;
      4'hC: segs = 7'b1000110;
      4'hD: segs = 7'b0100001;
      4'hE: segs = 7'b0000110;
      4'hF: segs = 7'b0001110;
      default: segs = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: a queue-based stack model predicts
// count, top value, error flag and the memory traffic of every operation.
module tb_stack_controller;

  logic       clk;
  logic       rst;
  logic [3:0] btns;
  logic [7:0] swtchs;
  logic       cs;
  logic       we;
  logic [6:0] addr;
  logic [7:0] data_out_ctrl;
  logic [7:0] data_bus;
  logic [7:0] leds;
  logic       err;
  logic [6:0] segs;
  logic [3:0] an;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] mem [0:127];
  logic [7:0] rdata;
  int         writeCount = 0;
  int         csCount    = 0;
  logic [6:0] lastAddr   = 7'd0;
  logic [7:0] lastData   = 8'd0;

  logic [7:0] stk[$];

  stack_controller #(.REFRESH_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .btns(btns),
    .swtchs(swtchs),
    .cs(cs),
    .we(we),
    .addr(addr),
    .data_out_ctrl(data_out_ctrl),
    .data_bus(data_bus),
    .leds(leds),
    .err(err),
    .segs(segs),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_bus = rdata;

  // Falling-edge memory plus a log of writes and chip-select cycles.
  always @(negedge clk) begin
    if (cs && we) begin
      mem[addr]  <= data_out_ctrl;
      writeCount <= writeCount + 1;
      lastAddr   <= addr;
      lastData   <= data_out_ctrl;
    end
    if (cs) begin
      rdata   <= mem[addr];
      csCount <= csCount + 1;
    end
  end

  // Segment pattern from the list of lit segments, inverted for active-low.
  function automatic logic [6:0] segFor(input logic [3:0] d);
    string      lit;
    logic [6:0] on;
    on = 7'd0;
    case (d)
      4'h0: lit = "abcdef";
      4'h1: lit = "bc";
      4'h2: lit = "abdeg";
      4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";
      4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";
      4'h7: lit = "abc";
      4'h8: lit = "abcdefg";
      4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";
      4'hB: lit = "cdefg";
      4'hC: lit = "adef";
      4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";
      default: lit = "aefg";
    endcase
    for (int i = 0; i < lit.len(); i++) on[int'(lit[i]) - 97] = 1'b1;
    return ~on;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press buttons for one cycle, then give the op time to return to IDLE.
  task automatic applyStimulus(input logic [3:0] b, input logic [7:0] sw);
    @(posedge clk); #1;
    btns   = b;
    swtchs = sw;
    @(posedge clk); #1;
    btns = 4'b0000;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Wait for each digit to be selected and compare it with the model top.
  task automatic checkOutput(input string tag, input logic [7:0] expTop);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (an == 4'b1110) found = 1;
    end
    check({tag, "_loDigitSeen"}, 32'(found), 32'd1);
    if (found) check({tag, "_loSegs"}, 32'(segs), 32'(segFor(expTop[3:0])));
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (an == 4'b1101) found = 1;
    end
    check({tag, "_hiDigitSeen"}, 32'(found), 32'd1);
    if (found) check({tag, "_hiSegs"}, 32'(segs), 32'(segFor(expTop[7:4])));
  endtask

  function automatic logic [7:0] modelTop();
    return (stk.size() > 0) ? stk[stk.size()-1] : 8'd0;
  endfunction

  // Run one op and compare everything the model predicts about it.
  task automatic runOp(input string tag, input logic [3:0] b, input logic [7:0] sw,
                       input bit showTop);
    int         w0, c0;
    int         expW, expCs;
    bit         expErr;
    logic [6:0] expAddr;
    logic [7:0] expData, x, y;
    w0 = writeCount;
    c0 = csCount;
    applyStimulus(b, sw);
    expW = 0; expCs = 0; expErr = 1; expAddr = 7'd0; expData = 8'd0;
    if (b[0]) begin
      if (stk.size() < 128) begin
        expAddr = 7'(127 - stk.size());
        expData = sw;
        stk.push_back(sw);
        expW = 1; expCs = 2; expErr = 0;
      end
    end else if (b[1]) begin
      if (stk.size() >= 1) begin
        void'(stk.pop_back());
        expCs = (stk.size() > 0) ? 1 : 0;
        expErr = 0;
      end
    end else if (b[2] || b[3]) begin
      if (stk.size() >= 2) begin
        x = stk.pop_back();
        y = stk.pop_back();
        expData = b[2] ? (y + x) : (y - x);
        expAddr = 7'(127 - stk.size());
        stk.push_back(expData);
        expW = 1; expCs = 4; expErr = 0;
      end
    end
    check({tag, "_leds"}, 32'(leds), 32'(stk.size()));
    check({tag, "_err"}, 32'(err), 32'(expErr));
    check({tag, "_writes"}, 32'(writeCount - w0), 32'(expW));
    check({tag, "_csCycles"}, 32'(csCount - c0), 32'(expCs));
    if (expW == 1) begin
      check({tag, "_wrAddr"}, 32'(lastAddr), 32'(expAddr));
      check({tag, "_wrData"}, 32'(lastData), 32'(expData));
    end
    if (showTop) checkOutput(tag, modelTop());
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    stk.delete();
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_an", 32'(an), 32'b1110);
    check("rst_segs", 32'(segs), 32'(segFor(4'h0)));
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int         w0;
    bit         seen;
    logic [3:0] b;
    rst    = 1'b1;
    btns   = 4'b0000;
    swtchs = 8'd0;
    repeat (3) @(posedge clk);
    doReset();

    // Directed scenarios
    runOp("push05", 4'b0001, 8'h05, 1);
    runOp("push03", 4'b0001, 8'h03, 1);
    runOp("add", 4'b0100, 8'h00, 1);
    runOp("popLast", 4'b0010, 8'h00, 1);
    runOp("popEmpty", 4'b0010, 8'h00, 1);
    runOp("pushClrErr", 4'b0001, 8'h02, 1);
    runOp("push03b", 4'b0001, 8'h03, 0);
    runOp("sub", 4'b1000, 8'h00, 1);
    runOp("addOne", 4'b0100, 8'h00, 0);
    runOp("pushPop", 4'b0011, 8'hA7, 1);
    runOp("addSub", 4'b1100, 8'h00, 1);

    // Randomized ops, biased toward pushes so the stack grows
    for (int n = 0; n < 60; n++) begin
      b = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) b = 4'b0001;
      runOp("rand", b, 8'($urandom), (n % 4) == 0);
    end

    // Fill the stack completely, then overflow
    doReset();
    for (int n = 0; n < 128; n++) runOp("fill", 4'b0001, 8'($urandom), 0);
    runOp("overflow", 4'b0001, 8'h5A, 1);

    // Reset while the ALU result is being written
    doReset();
    runOp("rA", 4'b0001, 8'h10, 0);
    runOp("rB", 4'b0001, 8'h20, 0);
    @(posedge clk); #1;
    btns = 4'b0100;
    @(posedge clk); #1;
    btns = 4'b0000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (we) seen = 1;
    end
    check("aluWrSeen", 32'(seen), 32'd1);
    w0 = writeCount;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stk.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_writes", 32'(writeCount - w0), 32'd0);
    check("abort_leds", 32'(leds), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    checkOutput("abort", 8'h00);
    runOp("afterAbort", 4'b0001, 8'h3C, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
